sparse_dot_seq: RTL
===================

Name: sparse_dot_seq

Overview:
- Sequencer for a 2:4-sparse dot product.
- Accepts a stream of 4-operand activation groups, each with a 4-bit nonzero mask and two compressed weights.
- Per group: selects the first two mask-selected operands, multiplies each with its weight, and accumulates over a programmed number of groups.
- Returns the sum through a valid/ready result port. Sits between the operand fetch stage and the result writeback in the sparse MAC datapath.

Parameters:
- DW, 16, operand/weight width, signed two's complement
- ACCW, 40, accumulator and result width
- LEN_W, 8, width of the group-count field

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  begin a job; sampled only in IDLE
- len  input  LEN_W  number of groups in the job; captured on start
- busy  output  1  high in every state except IDLE
- in_valid  input  1  group present on ain0..ain3/maskin/w0/w1
- in_ready  output  1  block accepts a group this cycle
- maskin  input  4  nonzero mask for the group, bit i marks ain_i
- ain0, ain1, ain2, ain3  input  DW each  activation operands
- w0  input  DW  weight paired with the lowest selected operand
- w1  input  DW  weight paired with the second-lowest selected operand
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_sum  output  ACCW  accumulated dot product
- mask_err  output  1  sticky per job; some accepted group had popcount(maskin) > 2

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: busy=0, in_ready=0, out_valid=0, out_sum=0, mask_err=0, accumulator=0, counter=0, state=IDLE.
- Selection (combinational per group):
  - lane0 = operand at the lowest set mask bit (bit0..bit3 all valid); lane1 = operand at the next set bit above it.
  - Missing lane (fewer than 2 bits set) = 0.
  - Bits beyond the second set bit are ignored and set mask_err.
- Arithmetic:
  - p0 = lane0*w0, p1 = lane1*w1, both signed 2*DW.
  - Group sum = p0+p1 at 2*DW+1 bits, sign-extended to ACCW, added to the accumulator.
  - Without the optional feature, accumulator wraps modulo 2^ACCW.
- Handshake: a group transfers when in_valid && in_ready. in_ready = (state==RUN) && (remaining count > 0).
- Pipeline: accept cycle registers p0/p1 (stage 1); next cycle adds into the accumulator (stage 2). Full throughput of one group per cycle.
- States:
  - IDLE: start=1 captures len, clears accumulator and mask_err. Goes to RUN, or to DONE if len==0 (out_sum=0).
  - RUN: each transfer decrements the counter. Transfer of the last group -> DRAIN.
  - DRAIN: stage 2 of the last group completes. Next cycle -> DONE with out_valid=1. Latency is 2 cycles from the last accept to out_valid.
  - DONE: out_valid=1, out_sum stable until out_valid && out_ready; then IDLE on the next cycle.
- Boundaries:
  - start while busy is ignored.
  - in_valid in IDLE/DRAIN/DONE is ignored (in_ready=0).
  - out_ready held high in DONE completes the handshake in the first DONE cycle.
  - len = 2^LEN_W-1 must count without wrap.
  - rst mid-job discards all state, including in-flight stage-1 products; out_valid drops the next cycle.
  - mask_err stays valid with out_sum until the handshake and clears on the next start.

Optional Feature:
- Macro SPARSE_DOT_SAT_EN.
- Defined: the accumulator add saturates to the signed ACCW range, +2^(ACCW-1)-1 / -2^(ACCW-1). A sticky internal flag ORs into mask_err's neighbour output sat_flag (extra 1-bit output port, reset 0, cleared on start).
- Undefined: wrap-around add, and the sat_flag port does not exist.

Test Plan:
- Reset, then start with len=1; group mask=0101, ain0=3, ain2=5, w0=2, w1=4 -> out_valid 2 cycles after accept, out_sum=26, mask_err=0.
- len=3, masks 0011/1000/1100, operands 1..4 per group (ain_i=i+1), all weights 1 -> sums 3, 4, 7; out_sum=14.
- len=0 with start -> DONE the next cycle, out_sum=0, no in_ready pulse.
- mask=1111, ain=1,2,3,4, w0=w1=-1 -> out_sum=-3, mask_err=1.
- len=4 with in_valid toggling every other cycle and out_ready held low for 5 cycles -> out_sum stable, single handshake, return to IDLE.
- rst asserted one cycle after the second accept of a len=4 job -> all outputs 0 next cycle. A new job then yields a correct sum with no residue from the aborted job.

Source files
------------

// File: rtl/sparse_dot_seq.sv
// Job sequencer for a 2:4-sparse dot product: selects two mask-marked operands per group, multiplies, accumulates.
// Optional SPARSE_DOT_SAT_EN: saturating accumulator plus a sticky sat_flag output.
module sparse_dot_seq #(
  parameter int DW    = 16,
  parameter int ACCW  = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       maskin,
  input  logic [DW-1:0]    ain0,
  input  logic [DW-1:0]    ain1,
  input  logic [DW-1:0]    ain2,
  input  logic [DW-1:0]    ain3,
  input  logic [DW-1:0]    w0,
  input  logic [DW-1:0]    w1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACCW-1:0]  out_sum,
  output logic             mask_err
`ifdef SPARSE_DOT_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_ZERO = '0;

  logic [1:0]          r_state;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_s1_valid;
  logic [2*DW-1:0]     r_p0;
  logic [2*DW-1:0]     r_p1;
  logic [ACCW-1:0]     r_acc;
  logic                r_mask_err;

  logic [DW-1:0]       w_ain [4];
  logic [DW-1:0]       w_lane0;
  logic [DW-1:0]       w_lane1;
  logic [2:0]          w_nsel;
  logic                w_excess;
  logic [2*DW-1:0]     w_p0;
  logic [2*DW-1:0]     w_p1;
  logic [2*DW:0]       w_gsum;
  logic [ACCW-1:0]     w_gext;
  logic [ACCW-1:0]     w_acc_next;
  logic                w_xfer;
  logic                w_start;

  assign w_ain[0] = ain0;
  assign w_ain[1] = ain1;
  assign w_ain[2] = ain2;
  assign w_ain[3] = ain3;

  // Walk the mask from bit 0 up; the first two set bits feed lane0/lane1, any further bit is an error.
  always_comb begin
    w_lane0 = '0;
    w_lane1 = '0;
    w_nsel  = '0;
    for (int i = 0; i < 4; i++) begin
      if (maskin[i]) begin
        if (w_nsel == 3'd0)      w_lane0 = w_ain[i];
        else if (w_nsel == 3'd1) w_lane1 = w_ain[i];
        w_nsel = w_nsel + 3'd1;
      end
    end
  end
  assign w_excess = (w_nsel > 3'd2);

  assign w_p0 = $signed({{DW{w_lane0[DW-1]}}, w_lane0}) * $signed({{DW{w0[DW-1]}}, w0});
  assign w_p1 = $signed({{DW{w_lane1[DW-1]}}, w_lane1}) * $signed({{DW{w1[DW-1]}}, w1});

  assign w_gsum = {r_p0[2*DW-1], r_p0} + {r_p1[2*DW-1], r_p1};
  assign w_gext = {{(ACCW-2*DW-1){w_gsum[2*DW]}}, w_gsum};

`ifdef SPARSE_DOT_SAT_EN
  logic [ACCW:0] w_wide;
  logic          w_ovf;
  logic          r_sat;

  assign w_wide = {r_acc[ACCW-1], r_acc} + {w_gext[ACCW-1], w_gext};
  assign w_ovf  = (w_wide[ACCW] != w_wide[ACCW-1]);
  // The extra top bit holds the true sign when the ACCW-bit result overflowed.
  assign w_acc_next = !w_ovf ? w_wide[ACCW-1:0] :
                      (w_wide[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}});
  assign sat_flag = r_sat;

  always_ff @(posedge clk) begin
    if (rst)                       r_sat <= 1'b0;
    else if (w_start)              r_sat <= 1'b0;
    else if (r_s1_valid && w_ovf)  r_sat <= 1'b1;
  end
`else
  assign w_acc_next = r_acc + w_gext;
`endif

  assign in_ready  = (r_state == S_RUN) && (r_cnt != CNT_ZERO);
  assign w_xfer    = in_valid && in_ready;
  assign w_start   = (r_state == S_IDLE) && start;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_sum   = r_acc;
  assign mask_err  = r_mask_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= len;
            r_state <= (len == CNT_ZERO) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: r_state <= S_DONE;
        S_DONE:  if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage 1 registers the products on accept; stage 2 folds them into the accumulator a cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_p0       <= '0;
      r_p1       <= '0;
      r_acc      <= '0;
      r_mask_err <= 1'b0;
    end else begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_p0 <= w_p0;
        r_p1 <= w_p1;
      end
      if (w_start) begin
        r_acc      <= '0;
        r_mask_err <= 1'b0;
      end else begin
        if (r_s1_valid)          r_acc      <= w_acc_next;
        if (w_xfer && w_excess)  r_mask_err <= 1'b1;
      end
    end
  end

endmodule
